// File: rtl/uart_block_stats_pkg.sv
// Shared types and constants for the UART block statistics engine.
// Response length depends on the UART_STATS_MIN_EN build option.
package uart_stats_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        RESP,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_TIMEOUT = 8'hE1;

    localparam int DEF_LEN_BYTES   = 2;
    localparam int DEF_SUM_BYTES   = 2;
    localparam int DEF_TIMEOUT_CYC = 27000;

    // status + sum + max (+ min when the min tracker is built)
    function automatic int resp_len(input int sum_bytes);
`ifdef UART_STATS_MIN_EN
        return sum_bytes + 3;
`else
        return sum_bytes + 2;
`endif
    endfunction

endpackage

// File: rtl/uart_block_stats_if.sv
// Byte-stream side of the statistics engine: UART rx pulses in,
// transmitter trigger/busy handshake out, plus status flags.
interface uart_block_stats_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_bsy;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       busy;
    logic       err_timeout;

    modport master (
        output rx_valid, rx_data, tx_bsy,
        input  tx_trig, tx_data, busy, err_timeout
    );

    modport slave (
        input  rx_valid, rx_data, tx_bsy,
        output tx_trig, tx_data, busy, err_timeout
    );

endinterface

// File: rtl/uart_block_stats_byte_sender.sv
// Walks a flattened response vector LSB byte first, one byte per
// full trigger/busy handshake with the UART transmitter.
module uart_stats_byte_sender
    import uart_stats_pkg::*;
#(
    parameter int NB = 5
) (
    input  logic          clk_27mhz,
    input  logic          rst,
    input  logic          start,
    input  logic [8*NB-1:0] resp,
    input  logic [7:0]    n,
    input  logic          tx_bsy,
    output logic          tx_trig,
    output logic [7:0]    tx_data,
    output logic          fin
);

    state_t     state;
    logic [7:0] idx;
    logic [7:0] cur;

    always_comb begin
        cur = resp[8*idx +: 8];
    end

    // idx already points past the byte just sent
    assign fin = (state == TX_WAIT_LO) && !tx_bsy && (idx == n);

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            tx_trig <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_trig <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RESP;
                        idx   <= '0;
                    end
                end
                RESP: begin
                    if (!tx_bsy) begin
                        tx_trig <= 1'b1;
                        tx_data <= cur;
                        idx     <= idx + 8'd1;
                        state   <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (tx_bsy) state <= TX_WAIT_LO;
                end
                TX_WAIT_LO: begin
                    if (!tx_bsy) state <= (idx == n) ? IDLE : RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_block_stats.sv
// Length-prefixed byte block statistics (sum/max, optional min) with
// inter-byte timeout; min tracking built when UART_STATS_MIN_EN is defined.
module uart_block_stats
    import uart_stats_pkg::*;
#(
    parameter int LEN_BYTES   = DEF_LEN_BYTES,
    parameter int SUM_BYTES   = DEF_SUM_BYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic               clk_27mhz,
    input logic               rst,
    uart_block_stats_if.slave bus
);

    localparam int LW   = 8 * LEN_BYTES;
    localparam int SW   = 8 * SUM_BYTES;
    localparam int NB   = resp_len(SUM_BYTES);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    state_t          state;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   len_nxt;
    logic [LW-1:0]   cnt;
    logic [7:0]      hdr_idx;
    logic [7:0]      hdr_sel;
    logic [SW-1:0]   sum_q;
    logic [7:0]      max_q;
    logic [7:0]      status_q;
    logic [7:0]      n_q;
    logic [TW-1:0]   tcnt;
    logic [8*NB-1:0] resp_vec;
    logic            hdr_last;
    logic            data_last;
    logic            tout;
    logic            start;
    logic            clr;
    logic            dat;
    logic            fin;

    assign hdr_sel = (state == LEN) ? hdr_idx : 8'd0;

    always_comb begin
        len_nxt = (state == IDLE) ? '0 : len_q;
        len_nxt[8*hdr_sel +: 8] = bus.rx_data;
    end

    assign hdr_last  = ((state == IDLE) && (LEN_BYTES == 1)) ||
                       ((state == LEN) && (hdr_idx == 8'(LEN_BYTES - 1)));
    assign data_last = (state == DATA) && bus.rx_valid &&
                       (cnt + 1'b1 == len_q);
    // a byte arriving on the expiry cycle wins over the abort
    assign tout      = ((state == LEN) || (state == DATA)) &&
                       !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYC));
    assign start     = tout || data_last ||
                       (bus.rx_valid && hdr_last && (len_nxt == '0));
    assign clr       = ((state == IDLE) && bus.rx_valid) || tout;
    assign dat       = (state == DATA) && bus.rx_valid;

    always_ff @(posedge clk_27mhz) begin
        if (rst || !((state == LEN) || (state == DATA)) || bus.rx_valid)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst || clr) begin
            sum_q <= '0;
            max_q <= 8'h00;
        end else if (dat) begin
            sum_q <= sum_q + SW'(bus.rx_data);
            if (bus.rx_data > max_q) max_q <= bus.rx_data;
        end
    end

`ifdef UART_STATS_MIN_EN
    logic [7:0] min_q;

    always_ff @(posedge clk_27mhz) begin
        if (rst || clr)
            min_q <= 8'hFF;
        else if (dat && (bus.rx_data < min_q))
            min_q <= bus.rx_data;
    end

    assign resp_vec = {min_q, max_q, sum_q, status_q};
`else
    assign resp_vec = {max_q, sum_q, status_q};
`endif

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            state           <= IDLE;
            len_q           <= '0;
            hdr_idx         <= '0;
            cnt             <= '0;
            status_q        <= STAT_OK;
            n_q             <= '0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        len_q    <= len_nxt;
                        hdr_idx  <= 8'd1;
                        cnt      <= '0;
                        status_q <= STAT_OK;
                        n_q      <= 8'(NB);
                        bus.busy <= 1'b1;
                        if (!hdr_last) state <= LEN;
                        else           state <= start ? RESP : DATA;
                    end
                end
                LEN: begin
                    if (tout) begin
                        bus.err_timeout <= 1'b1;
                        status_q        <= STAT_TIMEOUT;
                        n_q             <= 8'd1;
                        state           <= RESP;
                    end else if (bus.rx_valid) begin
                        len_q   <= len_nxt;
                        hdr_idx <= hdr_idx + 8'd1;
                        if (hdr_last) state <= start ? RESP : DATA;
                    end
                end
                DATA: begin
                    if (tout) begin
                        bus.err_timeout <= 1'b1;
                        status_q        <= STAT_TIMEOUT;
                        n_q             <= 8'd1;
                        state           <= RESP;
                    end else if (bus.rx_valid) begin
                        cnt <= cnt + 1'b1;
                        if (data_last) state <= RESP;
                    end
                end
                RESP: begin
                    if (fin) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_stats_byte_sender #(
        .NB (NB)
    ) u_sender (
        .clk_27mhz (clk_27mhz),
        .rst       (rst),
        .start     (start),
        .resp      (resp_vec),
        .n         (n_q),
        .tx_bsy    (bus.tx_bsy),
        .tx_trig   (bus.tx_trig),
        .tx_data   (bus.tx_data),
        .fin       (fin)
    );

endmodule

// File: tb/tb_uart_block_stats.sv
// Directed bench for uart_block_stats with a simple transmitter model;
// expected responses include min only when UART_STATS_MIN_EN is defined.
module tb_uart_block_stats;

    logic       clk_27mhz = 1'b0;
    logic       rst = 1'b1;
    logic       bsy_m = 1'b0;
    logic       hold = 1'b0;
    logic       prev_trig = 1'b0;
    int         bsy_left = 0;
    int         errs = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_block_stats_if bus();

    assign bus.tx_bsy = bsy_m | hold;

    uart_block_stats #(
        .LEN_BYTES   (2),
        .SUM_BYTES   (2),
        .TIMEOUT_CYC (27000)
    ) dut (
        .clk_27mhz (clk_27mhz),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk_27mhz = ~clk_27mhz;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // transmitter: busy for 4 cycles after every trigger
    always @(negedge clk_27mhz) begin
        if (bus.err_timeout === 1'b1) errs++;
        if (bus.tx_trig === 1'b1) begin
            chk("trig_b2b", {31'd0, prev_trig}, 0);
            chk("trig_bsy", {31'd0, bus.tx_bsy}, 0);
            got.push_back(bus.tx_data);
            bsy_m    = 1'b1;
            bsy_left = 4;
        end else if (bsy_left > 0) begin
            bsy_left--;
            if (bsy_left == 0) bsy_m = 1'b0;
        end
        prev_trig = bus.tx_trig;
    end

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk_27mhz);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_last(input logic [7:0] b, input string tag);
        send(b);
        chk({tag, "_lat1"}, {31'd0, bus.tx_trig}, 0);
        @(negedge clk_27mhz);
        chk({tag, "_lat2"}, {31'd0, bus.tx_trig}, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            @(negedge clk_27mhz);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, bus.busy}, 0);
    endtask

    task automatic expect_ok(input logic [15:0] s, input logic [7:0] mx,
                             input logic [7:0] mn);
        exp_q = '{8'h00, s[7:0], s[15:8], mx, mn};
`ifndef UART_STATS_MIN_EN
        exp_q.delete(exp_q.size() - 1);
`endif
    endtask

    task automatic cmp_resp(input string tag);
        logic [31:0] o;
        chk({tag, "_len"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            o = 'x;
            if (i < got.size()) o = {24'd0, got[i]};
            chk($sformatf("%s_b%0d", tag, i), o, {24'd0, exp_q[i]});
        end
        got.delete();
    endtask

    initial begin
        int n;
        int k;
        int e0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk_27mhz);
        chk("rst_trig", {31'd0, bus.tx_trig}, 0);
        chk("rst_data", {24'd0, bus.tx_data}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_err", {31'd0, bus.err_timeout}, 0);
        rst = 1'b0;
        @(negedge clk_27mhz);

        // basic block: 10 F0 05
        send(8'h03);
        chk("a_busy", {31'd0, bus.busy}, 1);
        send(8'h00);
        send(8'h10);
        send(8'hF0);
        send_last(8'h05, "a");
        wait_idle("a");
        expect_ok(16'h0105, 8'hF0, 8'h05);
        cmp_resp("a");

        // zero length: response straight after the header
        send(8'h00);
        send_last(8'h00, "n0");
        wait_idle("n0");
        expect_ok(16'h0000, 8'h00, 8'hFF);
        cmp_resp("n0");

        // 258 bytes, sum wraps: 257*FF + 07 = 0x10006
        send(8'h02);
        send(8'h01);
        for (int i = 0; i < 257; i++) send(8'hFF);
        send_last(8'h07, "wrap");
        wait_idle("wrap");
        expect_ok(16'h0006, 8'hFF, 8'h07);
        cmp_resp("wrap");

        // timeout after two of five bytes
        e0 = errs;
        send(8'h05);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 27100) begin
            @(negedge clk_27mhz);
            n++;
        end
        chk("tout_lat", n, 27001);
        chk("tout_busy", {31'd0, bus.busy}, 1);
        @(negedge clk_27mhz);
        chk("tout_pulse", {31'd0, bus.err_timeout}, 0);
        wait_idle("tout");
        chk("tout_cnt", errs - e0, 1);
        exp_q = '{8'hE1};
        cmp_resp("tout");

        // byte lands exactly on the expiry cycle: no abort
        e0 = errs;
        send(8'h02);
        send(8'h00);
        send(8'hA1);
        repeat (27000) @(negedge clk_27mhz);
        send_last(8'hB2, "edge");
        wait_idle("edge");
        chk("edge_err", errs - e0, 0);
        expect_ok(16'h0153, 8'hB2, 8'hA1);
        cmp_resp("edge");

        // transmitter held busy mid-response
        send(8'h01);
        send(8'h00);
        send_last(8'h42, "hold");
        n = 0;
        while (got.size() < 2 && n < 200) begin
            @(negedge clk_27mhz);
            n++;
        end
        hold = 1'b1;
        k = got.size();
        chk("hold_pre", k, 2);
        repeat (500) @(negedge clk_27mhz);
        chk("hold_trig", got.size(), k);
        chk("hold_busy", {31'd0, bus.busy}, 1);
        hold = 1'b0;
        wait_idle("hold");
        expect_ok(16'h0042, 8'h42, 8'h42);
        cmp_resp("hold");

        // reset after the third response byte
        send(8'h01);
        send(8'h00);
        send(8'h33);
        n = 0;
        while (got.size() < 3 && n < 200) begin
            @(negedge clk_27mhz);
            n++;
        end
        chk("rst3_pre", got.size(), 3);
        rst = 1'b1;
        @(negedge clk_27mhz);
        chk("rst3_trig", {31'd0, bus.tx_trig}, 0);
        chk("rst3_busy", {31'd0, bus.busy}, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk_27mhz);
        chk("rst3_quiet", got.size(), 3);
        got.delete();
        send(8'h02);
        send(8'h00);
        send(8'h01);
        send_last(8'h02, "fresh");
        wait_idle("fresh");
        expect_ok(16'h0003, 8'h02, 8'h01);
        cmp_resp("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
